// File: rtl/dmem_io_if.sv
// Core data-side bus plus output-FIFO sink handshake for dmem_io.
// slave = memory stage side, master = core/sink/bench side.
interface dmem_io_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        fault;

  modport slave (
    input  memwrite, addr, writedata, out_ready,
    output readdata, out_data, out_valid, fault
  );

  modport master (
    output memwrite, addr, writedata, out_ready,
    input  readdata, out_data, out_valid, fault
  );
endinterface

// File: rtl/dmem_io.sv
// Data memory stage: RAM, store-fed output FIFO, status/cycle registers; loads are 0-cycle combinational.
// Sink backpressure via out_ready; a store to a full FIFO with no same-cycle pop is dropped and flags overflow.
module dmem_io #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  dmem_io_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [31:0] FIFO_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

  typedef struct packed {
    logic [27:0] rsvd;
    logic        overflow;
    logic        fault;
    logic        full;
    logic        empty;
  } status_t;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   fq  [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          fault_q, overflow_q;
  logic [31:0]   cycles;

  logic          aligned, sel_ram, sel_fifo, sel_status, sel_cycles;
  logic [AW-1:0] ram_idx;
  logic          ram_we, push_req, push_ok, pop, status_wr, cycles_wr;
  logic          fault_set, overflow_set;
  logic [31:0]   head_dat;
  status_t       status;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Register targets decode on the word address; addr[1:0] only matters for store alignment.
  assign aligned    = (bus.addr[1:0] == 2'b00);
  assign sel_ram    = !bus.addr[31];
  assign sel_fifo   = (bus.addr[31:2] == FIFO_ADDR[31:2]);
  assign sel_status = (bus.addr[31:2] == STATUS_ADDR[31:2]);
  assign sel_cycles = (bus.addr[31:2] == CYCLES_ADDR[31:2]);
  assign ram_idx    = bus.addr[AW+1:2];

  assign ram_we       = bus.memwrite && aligned && sel_ram;
  assign push_req     = bus.memwrite && aligned && sel_fifo;
  assign status_wr    = bus.memwrite && aligned && sel_status;
  assign cycles_wr    = bus.memwrite && aligned && sel_cycles;
  assign fault_set    = bus.memwrite && !aligned;
  assign pop          = bus.out_valid && bus.out_ready;
  assign push_ok      = push_req && ((count != CNT_FULL) || pop);
  assign overflow_set = push_req && !push_ok;

  assign head_dat      = (count != '0) ? fq[head] : 32'h0;
  assign bus.out_data  = head_dat;
  assign bus.out_valid = (count != '0);
  assign bus.fault     = fault_q;

  always_comb begin
    status          = '0;
    status.empty    = (count == '0);
    status.full     = (count == CNT_FULL);
    status.fault    = fault_q;
    status.overflow = overflow_q;
  end

  always_comb begin
    bus.readdata = 32'h0;
    if (sel_ram)         bus.readdata = mem[ram_idx];
    else if (sel_fifo)   bus.readdata = head_dat;
    else if (sel_status) bus.readdata = status;
    else if (sel_cycles) bus.readdata = cycles;
  end

  // Storage arrays carry no reset; a store coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (reset && ram_we)  mem[ram_idx] <= bus.writedata;
    if (reset && push_ok) fq[tail]     <= bus.writedata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
      cycles     <= 32'h0;
    end else begin
      if (push_ok) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      // Set beats a same-cycle write-1-to-clear.
      fault_q    <= fault_set    | (fault_q    & ~(status_wr & bus.writedata[2]));
      overflow_q <= overflow_set | (overflow_q & ~(status_wr & bus.writedata[3]));
      cycles     <= cycles_wr ? bus.writedata : cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM aliasing, FIFO order/overflow, fault W1C, CYCLES wrap, mid-run reset.
module tb_dmem_io;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  dmem_io_if bus ();

  dmem_io #(.MEM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    bus.memwrite = 1'b0;
    bus.addr     = a;
    #1;
  endtask

  localparam logic [31:0] A_FIFO = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

  initial begin
    bus.memwrite  = 1'b0;
    bus.addr      = 32'h0;
    bus.writedata = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state and CYCLES counting from 0
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_fault", {31'h0, bus.fault}, 32'h0);
    load(A_STAT); chk("rst_status", bus.readdata, 32'h1);
    load(A_CYC);  chk("cyc_first", bus.readdata, 32'h0);
    repeat (5) tick();
    chk("cyc_plus5", bus.readdata, 32'h5);

    // CYCLES load and wrap
    store(A_CYC, 32'hFFFF_FFFE);
    load(A_CYC); chk("cyc_load", bus.readdata, 32'hFFFF_FFFE);
    tick();      chk("cyc_max", bus.readdata, 32'hFFFF_FFFF);
    tick();      chk("cyc_wrap", bus.readdata, 32'h0);

    // RAM with aliasing and unmapped high addresses
    store(32'h0000_0010, 32'hDEAD_BEEF);
    store(32'h0000_003C, 32'h1234_5678);
    load(32'h0000_0010); chk("ram_rd", bus.readdata, 32'hDEAD_BEEF);
    load(32'h0000_0110); chk("ram_alias", bus.readdata, 32'hDEAD_BEEF);
    load(32'h0000_003E); chk("ram_rd_lowbits", bus.readdata, 32'h1234_5678);
    load(32'hFFFF_000C); chk("unmapped_rd", bus.readdata, 32'h0);
    store(32'h8000_0010, 32'h5555_5555);
    load(32'h0000_0010); chk("unmapped_wr", bus.readdata, 32'hDEAD_BEEF);

    // Misaligned store, W1C, set-wins
    store(32'h0000_0012, 32'hCAFE_F00D);
    load(32'h0000_0010); chk("mis_ram", bus.readdata, 32'hDEAD_BEEF);
    chk("mis_fault", {31'h0, bus.fault}, 32'h1);
    load(A_STAT); chk("mis_status", bus.readdata, 32'h5);
    store(A_STAT, 32'h4);
    chk("w1c_fault", {31'h0, bus.fault}, 32'h0);
    load(A_STAT); chk("w1c_status", bus.readdata, 32'h1);
    store(32'hFFFF_0006, 32'h4);
    chk("setwins_fault", {31'h0, bus.fault}, 32'h1);
    store(A_STAT, 32'h4);

    // FIFO fill, overflow, drain
    for (int i = 1; i <= 4; i++) store(A_FIFO, i);
    load(A_STAT); chk("fifo_full_status", bus.readdata, 32'h2);
    store(A_FIFO, 32'd5);
    load(A_STAT); chk("fifo_ovf_status", bus.readdata, 32'hA);
    chk("fifo_head_after_ovf", bus.out_data, 32'd1);
    load(A_FIFO); chk("fifo_data_rd", bus.readdata, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("drain_data", bus.out_data, i);
      tick();
    end
    chk("drain_empty_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("drain_empty_data", bus.out_data, 32'h0);
    load(A_STAT); chk("drain_status", bus.readdata, 32'h9);
    load(A_FIFO); chk("empty_fifo_rd", bus.readdata, 32'h0);
    store(A_STAT, 32'h8);
    load(A_STAT); chk("ovf_clear", bus.readdata, 32'h1);

    // Push into full FIFO while popping
    bus.out_ready = 1'b0;
    for (int i = 10; i <= 13; i++) store(A_FIFO, i);
    bus.out_ready = 1'b1;
    store(A_FIFO, 32'd9);
    load(A_STAT); chk("pushpop_status", bus.readdata, 32'h2);
    chk("pushpop_d0", bus.out_data, 32'd11);
    tick(); chk("pushpop_d1", bus.out_data, 32'd12);
    tick(); chk("pushpop_d2", bus.out_data, 32'd13);
    tick(); chk("pushpop_d3", bus.out_data, 32'd9);
    tick(); chk("pushpop_done", {31'h0, bus.out_valid}, 32'h0);
    load(A_STAT); chk("pushpop_ovf", bus.readdata, 32'h1);

    // Reset mid-operation with concurrent store and pop request
    bus.out_ready = 1'b0;
    for (int i = 33; i <= 35; i++) store(A_FIFO, i);
    store(32'h0000_0021, 32'h0);
    store(A_CYC, 32'd100);
    load(A_STAT); chk("pre_rst_status", bus.readdata, 32'h4);
    load(A_CYC);  chk("pre_rst_cycles", bus.readdata, 32'd100);
    bus.out_ready = 1'b1;
    reset = 1'b0;
    store(A_FIFO, 32'h77);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    chk("post_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("post_rst_data", bus.out_data, 32'h0);
    chk("post_rst_fault", {31'h0, bus.fault}, 32'h0);
    load(A_STAT); chk("post_rst_status", bus.readdata, 32'h1);
    load(A_CYC);  chk("post_rst_cycles", bus.readdata, 32'h0);
    load(32'h0000_0010); chk("post_rst_ram", bus.readdata, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
